// File: rtl/vga_mem_pkg.sv
// Shared widths, FSM state and read-owner tag types for the VGA frame-memory arbiter.
// Pure type/constant package; no logic, no latency, no backpressure.
package vga_mem_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    SCAN,
    CPU
  } owner_t;

endpackage

// File: rtl/vga_word_fifo.sv
// Show-ahead synchronous FIFO: head word visible while out_valid; a push shows at the output next cycle.
// Pop when empty is ignored; push when full is dropped (the producer keeps credit so this never happens).
module vga_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && (count != FULL_C);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares the single-port frame RAM between the scanout line fetcher and the CPU Avalon slave.
// Grant is combinational, read data one cycle later; CPU stalls via waitrequest only while fetch credit is low.
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_start,
  input  logic [ADDR_W-1:0] scan_base,
  input  logic [ADDR_W-1:0] scan_len,
  output logic              scan_busy,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              pix_ready,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0] LOW_C   = (CNT_W + 1)'(LOW_WATER);

  arb_state_t        state_q, state_d;
  owner_t            tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit;
  logic              fetch_req;
  logic              cpu_req;
  logic              fetch_gnt;
  logic              cpu_gnt;

  // Credit counts the scan read still in flight so the FIFO can never be oversubscribed.
  assign credit    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, (tag_q == SCAN)};
  assign fetch_req = (state_q == FETCH) && (credit < DEPTH_C);
  assign cpu_req   = cpu_read || cpu_write;
  assign fetch_gnt = !reset && fetch_req && ((credit < LOW_C) || !cpu_req);
  assign cpu_gnt   = !reset && cpu_req && !fetch_gnt;

  assign cpu_waitrequest   = cpu_req && !cpu_gnt;
  assign cpu_readdatavalid = (tag_q == CPU);
  assign cpu_readdata      = mem_readdata;
  assign scan_busy         = (state_q != IDLE);
  assign mem_clken         = 1'b1;
  assign mem_writedata     = cpu_writedata;

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = addr_q;
    mem_byteenable = 4'h0;
    if (fetch_gnt) begin
      mem_chipselect = 1'b1;
      mem_byteenable = 4'hF;
    end else if (cpu_gnt) begin
      mem_chipselect = 1'b1;
      mem_write      = cpu_write;
      mem_address    = cpu_address;
      mem_byteenable = cpu_byteenable;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    tag_d    = NONE;
    case (state_q)
      IDLE: begin
        if (scan_start && (scan_len != '0)) begin
          state_d  = FETCH;
          addr_d   = scan_base;
          remain_d = scan_len;
        end
      end
      FETCH: begin
        if (fetch_gnt) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_q == SCAN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A simultaneous read+write is a write, so it leaves no read to return.
    if (fetch_gnt) begin
      tag_d = SCAN;
    end else if (cpu_gnt && !cpu_write) begin
      tag_d = CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tag_q    <= NONE;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  vga_word_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_q == SCAN),
    .push_data (mem_readdata),
    .pop       (pix_ready),
    .out_valid (pix_valid),
    .out_data  (pix_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: RAM model, queue-based reference of FIFO/credit/grant rules,
// table-driven CPU ops, directed multi-cycle sequences and a randomized phase.
module tb_vga_mem_arbiter;
  import vga_mem_pkg::*;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LOW   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          scan_start;
  logic [AW-1:0] scan_base;
  logic [AW-1:0] scan_len;
  logic          scan_busy;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic [AW-1:0] cpu_address;
  logic          cpu_read;
  logic          cpu_write;
  logic [DW-1:0] cpu_writedata;
  logic [3:0]    cpu_byteenable;
  logic          cpu_waitrequest;
  logic [DW-1:0] cpu_readdata;
  logic          cpu_readdatavalid;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic [3:0]    mem_byteenable;
  logic          mem_clken;
  logic [DW-1:0] mem_readdata;

  always #5 clk = ~clk;

  vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .LOW_WATER(LOW)) dut (
    .clk(clk), .reset(reset),
    .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len), .scan_busy(scan_busy),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return {8'hA5, 10'd0, a};
  endfunction

  // Frame RAM: unwritten words read back as pat(address).
  logic [31:0] ram     [16384];
  bit          written [16384];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        logic [31:0] w;
        w = written[mem_address] ? ram[mem_address] : pat(mem_address);
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
        ram[mem_address]     <= w;
        written[mem_address] <= 1'b1;
      end else begin
        mem_readdata <= written[mem_address] ? ram[mem_address] : pat(mem_address);
      end
    end
  end

  // Reference model state
  logic [31:0]   exp_mem [16384];
  logic [31:0]   exp_fifo[$];
  int            remaining;
  logic [AW-1:0] next_addr;
  bit            infl_scan, infl_cpu;
  logic [31:0]   infl_scan_dat, infl_cpu_dat;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cs_count = 0;
  int pop_count = 0;

  bit            s_valid, s_busy, s_cs, s_wait, s_rdv, m_push;
  logic [31:0]   s_rdata;
  logic [AW-1:0] s_addr;
  int            s_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample and check at negedge, then advance the model across the posedge.
  task automatic cycle();
    bit cpu_req, fetch, cpu_go, popping, idle_now;
    int credit;
    @(negedge clk);
    s_cyc   = cyc;
    s_valid = pix_valid;
    s_busy  = scan_busy;
    s_cs    = mem_chipselect;
    s_wait  = cpu_waitrequest;
    s_rdv   = cpu_readdatavalid;
    s_rdata = cpu_readdata;
    s_addr  = mem_address;
    cpu_req  = cpu_read || cpu_write;
    credit   = exp_fifo.size() + int'(infl_scan);
    fetch    = (remaining > 0) && (credit < DEPTH) && ((credit < LOW) || !cpu_req);
    cpu_go   = cpu_req && !fetch;
    m_push   = infl_scan;
    popping  = pix_ready && (exp_fifo.size() > 0);
    idle_now = !((remaining > 0) || infl_scan);
    if (!reset) begin
      check("scan_busy", scan_busy, !idle_now);
      check("pix_valid", pix_valid, exp_fifo.size() > 0);
      if (exp_fifo.size() > 0) check("pix_data", pix_data, exp_fifo[0]);
      check("waitrequest", cpu_waitrequest, cpu_req && fetch);
      check("chipselect", mem_chipselect, fetch || cpu_req);
      if (fetch) begin
        check("fetch_addr", mem_address, next_addr);
        check("fetch_we", mem_write, 0);
        check("fetch_be", mem_byteenable, 4'hF);
      end else if (cpu_go) begin
        check("cpu_addr", mem_address, cpu_address);
        check("cpu_we", mem_write, cpu_write);
        if (cpu_write) begin
          check("cpu_be", mem_byteenable, cpu_byteenable);
          check("cpu_wdata", mem_writedata, cpu_writedata);
        end
      end
      check("readdatavalid", cpu_readdatavalid, infl_cpu);
      if (infl_cpu) check("readdata", cpu_readdata, infl_cpu_dat);
    end
    if (mem_chipselect) cs_count++;
    @(posedge clk);
    cyc++;
    if (reset) begin
      exp_fifo.delete();
      infl_scan = 0;
      infl_cpu  = 0;
      remaining = 0;
    end else begin
      if (popping) begin
        void'(exp_fifo.pop_front());
        pop_count++;
      end
      if (infl_scan) exp_fifo.push_back(infl_scan_dat);
      infl_scan = fetch;
      if (fetch) begin
        infl_scan_dat = exp_mem[next_addr];
        next_addr++;
        remaining--;
      end
      infl_cpu = cpu_go && !cpu_write;
      if (cpu_go) begin
        if (cpu_write) begin
          for (int b = 0; b < 4; b++)
            if (cpu_byteenable[b]) exp_mem[cpu_address][8*b +: 8] = cpu_writedata[8*b +: 8];
        end else begin
          infl_cpu_dat = exp_mem[cpu_address];
        end
      end
      if (idle_now && scan_start && (scan_len != '0)) begin
        remaining = int'(scan_len);
        next_addr = scan_base;
      end
    end
    #1;
  endtask

  task automatic cpu_idle();
    cpu_read = 0; cpu_write = 0; cpu_address = '0; cpu_writedata = '0; cpu_byteenable = 4'h0;
  endtask

  task automatic start_scan(input logic [AW-1:0] base, input logic [AW-1:0] len);
    scan_base = base; scan_len = len; scan_start = 1;
    cycle();
    scan_start = 0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          exp_rdv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[9];
  logic [13:0] wrap_exp[4];
  logic [13:0] wrap_got[4];

  initial begin
    int pulse, first_valid, first_grant, last_push, busy_low, n, waits, p0, c0, rdvs;
    vecs[0] = '{1, 0, 14'h0030, 32'h0,        4'h0, 1, 32'hA5000030};
    vecs[1] = '{0, 1, 14'h0030, 32'h11223344, 4'h5, 0, 32'h0};
    vecs[2] = '{1, 0, 14'h0030, 32'h0,        4'h0, 1, 32'hA5220044};
    vecs[3] = '{1, 1, 14'h0031, 32'hCAFEF00D, 4'hF, 0, 32'h0};
    vecs[4] = '{1, 0, 14'h0031, 32'h0,        4'h0, 1, 32'hCAFEF00D};
    vecs[5] = '{0, 1, 14'h0032, 32'hFFFFFFFF, 4'h0, 0, 32'h0};
    vecs[6] = '{1, 0, 14'h0032, 32'h0,        4'h0, 1, 32'hA5000032};
    vecs[7] = '{0, 1, 14'h3FFF, 32'h12345678, 4'hC, 0, 32'h0};
    vecs[8] = '{1, 0, 14'h3FFF, 32'h0,        4'h0, 1, 32'h12343FFF};
    wrap_exp[0] = 14'h3FFE; wrap_exp[1] = 14'h3FFF; wrap_exp[2] = 14'h0000; wrap_exp[3] = 14'h0001;

    for (int i = 0; i < 16384; i++) exp_mem[i] = pat(14'(i));
    remaining = 0; next_addr = '0; infl_scan = 0; infl_cpu = 0;

    reset = 1; scan_start = 0; scan_base = '0; scan_len = '0; pix_ready = 0;
    cpu_idle();
    repeat (3) cycle();
    reset = 0;
    cycle();
    check("rst_scan_busy", s_busy, 0);
    check("rst_pix_valid", s_valid, 0);
    check("rst_readdatavalid", s_rdv, 0);
    check("rst_chipselect", s_cs, 0);
    check("rst_waitrequest", s_wait, 0);
    check("mem_clken", mem_clken, 1);

    // Basic burst timing
    pix_ready = 1;
    start_scan(14'h0100, 14'd4);
    pulse = s_cyc; first_valid = -1; first_grant = -1; last_push = -1; busy_low = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_cs && first_grant < 0) first_grant = s_cyc;
      if (s_valid && first_valid < 0) first_valid = s_cyc;
      if (m_push) last_push = s_cyc;
      if (!s_busy && busy_low < 0) busy_low = s_cyc;
    end
    check("basic_grant_latency", first_grant - pulse, 1);
    check("basic_pix_latency", first_valid - pulse, 3);
    check("basic_busy_fall", busy_low - last_push, 1);

    // Address wrap
    n = 0;
    start_scan(14'h3FFE, 14'd4);
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_cs && n < 4) begin wrap_got[n] = s_addr; n++; end
    end
    check("wrap_count", n, 4);
    for (int i = 0; i < 4; i++) check("wrap_addr", wrap_got[i], wrap_exp[i]);

    // Table of idle-time CPU operations
    for (int i = 0; i < 9; i++) begin
      cpu_read = vecs[i].rd; cpu_write = vecs[i].wr; cpu_address = vecs[i].addr;
      cpu_writedata = vecs[i].wdata; cpu_byteenable = vecs[i].be;
      cycle();
      check("tbl_wait", s_wait, 0);
      cpu_idle();
      cycle();
      check("tbl_rdv", s_rdv, vecs[i].exp_rdv);
      if (vecs[i].exp_rdv) check("tbl_rdata", s_rdata, vecs[i].exp_rdata);
    end

    // Backpressure: fetch must stop at FIFO_DEPTH outstanding words
    pix_ready = 0;
    c0 = cs_count;
    start_scan(14'h0200, 14'd40);
    repeat (30) cycle();
    check("bp_fetched", cs_count - c0, 16);
    check("bp_pix_valid", s_valid, 1);
    check("bp_busy", s_busy, 1);
    pix_ready = 1;
    p0 = pop_count;
    repeat (80) cycle();
    check("bp_popped", pop_count - p0, 40);
    check("bp_done", s_busy, 0);

    // CPU write shares the slot once credit reaches LOW_WATER
    pix_ready = 0;
    start_scan(14'h0400, 14'd20);
    cpu_write = 1; cpu_address = 14'h0010; cpu_writedata = 32'hDEADBEEF; cpu_byteenable = 4'b0011;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!s_wait) break;
      waits++;
    end
    check("share_wait_cycles", waits, 8);
    cpu_idle();
    cpu_read = 1; cpu_address = 14'h0010;
    cycle();
    check("share_rd_wait", s_wait, 0);
    cpu_idle();
    cycle();
    check("share_rdv", s_rdv, 1);
    check("share_rdata", s_rdata, 32'hA500BEEF);
    pix_ready = 1;
    repeat (40) cycle();

    // CPU only: one read per cycle, never stalled
    waits = 0; rdvs = 0;
    for (int i = 0; i < 20; i++) begin
      cpu_read = 1; cpu_address = 14'($urandom_range(0, 16383));
      cycle();
      if (s_wait) waits++;
      if (s_rdv) rdvs++;
    end
    cpu_idle();
    cycle();
    if (s_rdv) rdvs++;
    check("cpuonly_waits", waits, 0);
    check("cpuonly_rdvs", rdvs, 20);

    // Reset while fetching with a scan read in flight
    pix_ready = 0;
    start_scan(14'h0500, 14'd10);
    cycle();
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    cycle();
    check("rst_mid_pix_valid", s_valid, 0);
    check("rst_mid_rdv", s_rdv, 0);
    check("rst_mid_busy", s_busy, 0);
    pix_ready = 1;
    p0 = pop_count;
    start_scan(14'h0600, 14'd3);
    repeat (10) cycle();
    check("rst_mid_restart_words", pop_count - p0, 3);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      if (!((cpu_read || cpu_write) && s_wait)) begin
        int r;
        r = $urandom_range(0, 5);
        cpu_idle();
        cpu_address = 14'h2000 | 14'($urandom_range(0, 255));
        if (r == 1 || r == 2) cpu_read = 1;
        if (r == 3) cpu_write = 1;
        if (r == 4) begin cpu_read = 1; cpu_write = 1; end
        cpu_writedata  = $urandom;
        cpu_byteenable = 4'($urandom_range(0, 15));
      end
      scan_start = ($urandom_range(0, 9) == 0);
      scan_base  = 14'h3000 | 14'($urandom_range(0, 4095));
      scan_len   = 14'($urandom_range(0, 48));
      pix_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    scan_start = 0;
    cpu_idle();
    pix_ready = 1;
    repeat (120) cycle();
    check("rand_drain_fifo", s_valid, 0);
    check("rand_drain_busy", s_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Sequences and shares the single-port 16K x 32 on-chip frame memory between two requesters: a VGA scanout line fetcher (read-only burst) and a CPU-side Avalon-MM slave (read/write).
- Fetched pixel words are buffered in a small FIFO that feeds the pixel pipeline.
- The CPU receives every slot the fetcher does not need, so CPU access never starves.
- Sits between the VGA timing/pixel logic and the memory instance, inside the VGA subsystem.

Parameters:
ADDR_W, 14, word address width of the memory
DATA_W, 32, memory data width
FIFO_DEPTH, 16, pixel FIFO depth in words (power of 2)
LOW_WATER, 8, fetch has priority while credit < LOW_WATER

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
scan_start  in  1  one-cycle pulse: begin line fetch
scan_base  in  ADDR_W  first word address of the line
scan_len  in  ADDR_W  words to fetch; 0 = no-op
scan_busy  out  1  burst in progress or read in flight
pix_valid  out  1  FIFO not empty
pix_data  out  DATA_W  FIFO head word
pix_ready  in  1  pop FIFO head when pix_valid
cpu_address  in  ADDR_W  Avalon word address
cpu_read  in  1  Avalon read
cpu_write  in  1  Avalon write
cpu_writedata  in  DATA_W  write data
cpu_byteenable  in  4  byte lanes
cpu_waitrequest  out  1  request not accepted this cycle
cpu_readdata  out  DATA_W  read data
cpu_readdatavalid  out  1  cpu_readdata valid
mem_address  out  ADDR_W  to RAM
mem_chipselect  out  1  to RAM
mem_write  out  1  to RAM
mem_writedata  out  DATA_W  to RAM
mem_byteenable  out  4  to RAM
mem_clken  out  1  constant 1
mem_readdata  in  DATA_W  RAM q, valid 1 cycle after address

Behaviour:
- Reset values:
  - scan_busy, pix_valid, cpu_readdatavalid, mem_chipselect, mem_write: 0.
  - cpu_waitrequest: 1 only while a request is present and not granted.
  - FIFO is empty; counters and the in-flight tag are cleared.
- Reset mid-burst or with a read in flight: the in-flight read is discarded; no pix push and no readdatavalid follow.
- FSM states:
  - IDLE --scan_start & scan_len!=0--> FETCH. Loads addr=scan_base and remain=scan_len. scan_start is ignored in any other state.
  - FETCH --last word issued--> DRAIN.
  - DRAIN --in-flight read returned--> IDLE.
- scan_busy = (state != IDLE).
- credit = fifo_count + scan reads in flight (0 or 1).
- Per-cycle grant (combinational from registered state):
  - fetch_req = FETCH & credit < FIFO_DEPTH.
  - cpu_req = cpu_read | cpu_write.
  - Fetch wins if fetch_req & (credit < LOW_WATER | !cpu_req); otherwise CPU wins if cpu_req.
- Granted cycle drives mem_chipselect=1.
  - Fetch grant: mem_address=addr, mem_write=0, mem_byteenable=4'hF. addr increments modulo 2^ADDR_W (wrap 16383 -> 0); remain decrements.
  - CPU grant: mem_* = cpu_*; cpu_waitrequest=0.
  - CPU request not granted: cpu_waitrequest=1.
- cpu_read & cpu_write together: treated as write.
- Read latency: a registered tag records the owner of each granted read.
  - Next cycle, mem_readdata is pushed into the FIFO (scan) or presented on cpu_readdata with cpu_readdatavalid=1 (CPU).
  - Writes return nothing.
  - At most one read is in flight; back-to-back grants every cycle are allowed.
- FIFO:
  - Push and pop in the same cycle are legal; the count is unchanged.
  - Pop when empty is ignored.
  - Overflow is impossible by credit rule; the bench asserts it.
  - First-word latency from scan_start: grant in cycle+1, pix_valid in cycle+3.

Decomposition:
- Package vga_mem_pkg: ADDR_W/DATA_W defaults, FSM state enum {IDLE, FETCH, DRAIN}, owner tag enum {NONE, SCAN, CPU}.
- One sub-module: vga_word_fifo.
  - Synchronous FIFO with show-ahead output, count output, and synchronous reset.
  - The arbiter instantiates it once.

Test Plan:
- Basic burst: reset, scan_start with base=0x0100 and len=4, pix_ready=1. Words from 0x0100..0x0103 appear in order, the first with pix_valid 3 cycles after the pulse. scan_busy falls the cycle after the last push.
- Wrap: base=0x3FFE, len=4. Addresses issued are 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Backpressure: len=40, pix_ready=0. Fetch stops at fifo_count=16 with no overflow. With pix_ready=1 all 40 words arrive in order, none lost or duplicated.
- Sharing and write:
  - CPU write 0xDEADBEEF, byteenable 4'b0011, to 0x0010 during a burst. The write is granted once credit >= LOW_WATER.
  - A subsequent CPU read returns 0x????BEEF with old upper bytes, readdatavalid exactly 1 cycle after the grant.
- CPU only: no scan activity, continuous CPU reads. cpu_waitrequest is 0 every cycle, throughput is 1 per cycle, and each readdatavalid follows its grant by 1 cycle.
- Reset mid-operation: assert reset in FETCH with a read in flight. Next cycle pix_valid=0, cpu_readdatavalid=0, scan_busy=0, and a later scan_start works normally.
